// File: rtl/req_pend_binenc.sv
// Sticky request-pending vector feeding a highest-index-wins binary encoder with valid/ready output.
// Optional REQ_PEND_OVF_EN adds a sticky lost-request flag (ovf) with clear input (ovf_clr).
module req_pend_binenc #(
  parameter int unsigned A_width    = 32,
  parameter int unsigned ADDR_width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [A_width-1:0]    req_in,
  input  logic [A_width-1:0]    req_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_width-1:0] out_addr,
  output logic [A_width-1:0]    pend,
  output logic                  empty
`ifdef REQ_PEND_OVF_EN
  ,
  input  logic                  ovf_clr,
  output logic                  ovf
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state, state_n;
  logic [A_width-1:0]      elig, take, pend_n;
  logic                    any_elig, take_en, valid_n;
  logic [ADDR_width-1:0]   sel, addr_n;

  // Ascending scan so the highest eligible index is the last one written.
  always_comb begin
    elig     = pend & req_mask;
    any_elig = |elig;
    sel      = '0;
    for (int unsigned i = 0; i < A_width; i++) begin
      if (elig[i]) sel = ADDR_width'(i);
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = out_addr;
    valid_n = out_valid;
    take_en = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          take_en = 1'b1;
          addr_n  = sel;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (any_elig) begin
            take_en = 1'b1;
            addr_n  = sel;
          end else begin
            addr_n  = '1;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        addr_n  = '1;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
    take   = take_en ? (A_width'(1) << sel) : '0;
    pend_n = (pend & ~take) | req_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '1;
      empty     <= 1'b1;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      out_valid <= valid_n;
      out_addr  <= addr_n;
      // Built from next-state values so empty tracks the registered pend/out_valid exactly.
      empty     <= (pend_n == '0) && !valid_n;
    end
  end

`ifdef REQ_PEND_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (|(req_in & pend & ~take)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_req_pend_binenc.sv
// Scoreboard bench for req_pend_binenc: spec-level model predicts captured indices and per-cycle state.
module tb_req_pend_binenc;
  localparam int AW = 32;
  localparam int DW = 6;
  localparam int NONE = (1 << DW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, out_ready, out_valid, empty;
  logic [AW-1:0] req_in, req_mask, pend;
  logic [DW-1:0] out_addr;
`ifdef REQ_PEND_OVF_EN
  logic ovf_clr, ovf;
`endif

  req_pend_binenc #(.A_width(AW), .ADDR_width(DW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_mask(req_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .pend(pend), .empty(empty)
`ifdef REQ_PEND_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit [AW-1:0] m_pend = '0;
  bit m_valid = 1'b0;
  int m_addr = NONE;
  bit m_ovf = 1'b0;
  bit started = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input bit [AW-1:0] v);
    for (int i = AW - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Advance the model across one clock edge using the inputs that were present at that edge.
  function automatic void model_step();
    int hi;
    bit accept;
    bit [AW-1:0] tk;
    if (rst) begin
      m_pend = '0; m_valid = 1'b0; m_addr = NONE; m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    hi = highest(m_pend & req_mask);
    accept = m_valid && out_ready;
    tk = '0;
    if (!m_valid || accept) begin
      if (hi >= 0) begin
        tk[hi] = 1'b1;
        exp_q.push_back(hi);
        m_valid = 1'b1;
        m_addr = hi;
      end else begin
        m_valid = 1'b0;
        m_addr = NONE;
      end
    end
`ifdef REQ_PEND_OVF_EN
    if ((req_in & m_pend & ~tk) != '0) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
`endif
    m_pend = (m_pend & ~tk) | req_in;
  endfunction

  task automatic tick(input logic r, input logic [AW-1:0] rq, input logic [AW-1:0] mk, input logic rd);
    rst = r; req_in = rq; req_mask = mk; out_ready = rd;
    @(posedge clk);
    #1;
    model_step();
    started = 1'b1;
  endtask

  // Monitor: per-cycle state against the model, and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (started) begin
      check("pend", pend, m_pend);
      check("out_valid", out_valid, m_valid);
      check("out_addr", out_addr, m_addr);
      check("empty", empty, (m_pend == '0) && !m_valid);
`ifdef REQ_PEND_OVF_EN
      check("ovf", ovf, m_ovf);
`endif
      if (out_valid && out_ready && !rst) begin
        check("hs_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("hs_addr", out_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] rq, mk;
`ifdef REQ_PEND_OVF_EN
    ovf_clr = 1'b0;
`endif
    tick(1, '0, '1, 0);
    tick(1, '0, '1, 0);
    tick(0, '0, '1, 0);
    tick(0, '0, '1, 0);

    // Two-request burst, drained back to back.
    tick(0, 32'h0000_0012, '1, 1);
    for (int i = 0; i < 5; i++) tick(0, '0, '1, 1);

    // Held index must survive mask change; then lower index follows.
    tick(0, 32'h8000_0001, '1, 0);
    tick(0, '0, '1, 0);
    tick(0, '0, 32'h7FFF_FFFF, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 32'h7FFF_FFFF, 0);
    for (int i = 0; i < 4; i++) tick(0, '0, '1, 1);

    // Re-pend of the held line while it waits.
    tick(0, 32'h0000_0080, '1, 0);
    tick(0, '0, '1, 0);
    tick(0, 32'h0000_0080, '1, 0);
    for (int i = 0; i < 5; i++) tick(0, '0, '1, 1);

    // Reset mid-handshake with everything pending.
    tick(0, '1, '1, 0);
    tick(0, '0, '1, 0);
    tick(0, '0, '1, 0);
    tick(1, '0, '1, 1);
    tick(0, '0, '1, 1);
    tick(0, '0, '1, 1);

`ifdef REQ_PEND_OVF_EN
    tick(0, 32'h0000_0008, 32'hFFFF_FFF7, 0);
    tick(0, 32'h0000_0008, 32'hFFFF_FFF7, 0);
    tick(0, '0, 32'hFFFF_FFF7, 0);
    ovf_clr = 1'b1;
    tick(0, '0, 32'hFFFF_FFF7, 0);
    ovf_clr = 1'b0;
    tick(0, '0, 32'hFFFF_FFF7, 0);
    ovf_clr = 1'b1;
    tick(0, 32'h0000_0008, 32'hFFFF_FFF7, 0);
    ovf_clr = 1'b0;
    tick(0, '0, '1, 1);
    tick(1, '0, '1, 1);
`endif

    for (int n = 0; n < 2000; n++) begin
      rq = $urandom() & $urandom() & $urandom() & $urandom();
      if ($urandom_range(3) == 0) rq = '0;
      mk = ($urandom_range(3) == 0) ? $urandom() : '1;
`ifdef REQ_PEND_OVF_EN
      ovf_clr = ($urandom_range(7) == 0);
`endif
      tick($urandom_range(99) == 0, rq, mk, $urandom_range(3) != 0);
    end
    for (int n = 0; n < 40; n++) tick(0, '0, '1, 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
